fifo: RTL and testbench



---
 rtl/fifo_if.sv | 29 ++
 rtl/fifo.sv | 67 ++++++
 tb/tb_fifo.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fifo_if.sv
// fifo_if: producer/consumer signals of the fifo; overflow/underflow exist only with FIFO_ERR_FLAGS_EN.
interface fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif
    modport master (
        output wr, rd, data_in,
        input  data_out, empty, full
`ifdef FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );
    modport slave (
        input  wr, rd, data_in,
        output data_out, empty, full
`ifdef FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/fifo.sv
// fifo: single-clock FIFO with registered read data and full/empty protection.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic   clk,
    input logic   reset,
    fifo_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty, full, wr_ok, rd_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign wr_ok = bus.wr && !full;
    assign rd_ok = bus.rd && !empty;

    always_ff @(posedge clk)
        if (wr_ok) mem[wptr] <= bus.data_in;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (wr_ok) wptr <= inc(wptr);
            if (rd_ok) begin
                rptr <= inc(rptr);
                dout <= mem[rptr];
            end
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end

    assign bus.data_out = dout;
    assign bus.empty    = empty;
    assign bus.full     = full;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow, underflow;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (bus.wr & full);
            underflow <= underflow | (bus.rd & empty);
        end

    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
`endif
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed vector table, async reset check, then random traffic against a queue model.
module tb_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    fifo_if #(.DATA_WIDTH(DW)) bus();
    fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          empty;
        logic          full;
    } vec_t;

    vec_t tv [31];
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_dout;
    logic m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        bus.wr = w;
        bus.rd = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 8'd1,  8'd0,  1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 8'd2,  8'd0,  1'b0, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 8'd3,  8'd0,  1'b0, 1'b1};
        tv[4]  = '{1'b0, 1'b1, 8'd0,  8'd0,  1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 8'd0,  8'd1,  1'b0, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 8'd0,  8'd2,  1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 8'd0,  8'd3,  1'b1, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 8'd0,  8'd3,  1'b0, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 8'd1,  8'd3,  1'b0, 1'b0};
        tv[10] = '{1'b1, 1'b0, 8'd2,  8'd3,  1'b0, 1'b0};
        tv[11] = '{1'b1, 1'b0, 8'd3,  8'd3,  1'b0, 1'b1};
        tv[12] = '{1'b1, 1'b0, 8'd4,  8'd3,  1'b0, 1'b1};
        tv[13] = '{1'b0, 1'b1, 8'd0,  8'd0,  1'b0, 1'b0};
        tv[14] = '{1'b0, 1'b1, 8'd0,  8'd1,  1'b0, 1'b0};
        tv[15] = '{1'b0, 1'b1, 8'd0,  8'd2,  1'b0, 1'b0};
        tv[16] = '{1'b0, 1'b1, 8'd0,  8'd3,  1'b1, 1'b0};
        tv[17] = '{1'b0, 1'b1, 8'd0,  8'd3,  1'b1, 1'b0};
        tv[18] = '{1'b1, 1'b1, 8'd9,  8'd3,  1'b0, 1'b0};
        tv[19] = '{1'b1, 1'b0, 8'd10, 8'd3,  1'b0, 1'b0};
        tv[20] = '{1'b1, 1'b1, 8'd11, 8'd9,  1'b0, 1'b0};
        tv[21] = '{1'b0, 1'b1, 8'd0,  8'd10, 1'b0, 1'b0};
        tv[22] = '{1'b0, 1'b1, 8'd0,  8'd11, 1'b1, 1'b0};
        tv[23] = '{1'b1, 1'b0, 8'd20, 8'd11, 1'b0, 1'b0};
        tv[24] = '{1'b1, 1'b0, 8'd21, 8'd11, 1'b0, 1'b0};
        tv[25] = '{1'b1, 1'b0, 8'd22, 8'd11, 1'b0, 1'b0};
        tv[26] = '{1'b1, 1'b0, 8'd23, 8'd11, 1'b0, 1'b1};
        tv[27] = '{1'b1, 1'b1, 8'd99, 8'd20, 1'b0, 1'b0};
        tv[28] = '{1'b0, 1'b1, 8'd0,  8'd21, 1'b0, 1'b0};
        tv[29] = '{1'b0, 1'b1, 8'd0,  8'd22, 1'b0, 1'b0};
        tv[30] = '{1'b0, 1'b1, 8'd0,  8'd23, 1'b1, 1'b0};

        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_full", 32'(bus.full), 32'd0);
        chk("reset_dout", 32'(bus.data_out), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("reset_ovf", 32'(bus.overflow), 32'd0);
        chk("reset_unf", 32'(bus.underflow), 32'd0);
`endif

        foreach (tv[i]) begin
            cyc(tv[i].wr, tv[i].rd, tv[i].din);
            chk($sformatf("vec%0d_dout", i), 32'(bus.data_out), 32'(tv[i].dout));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tv[i].empty));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(tv[i].full));
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("sticky_ovf", 32'(bus.overflow), 32'd1);
        chk("sticky_unf", 32'(bus.underflow), 32'd1);
`endif

        // Reset mid-fill must take effect between clock edges.
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'h66);
        bus.wr = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_empty", 32'(bus.empty), 32'd1);
        chk("async_full", 32'(bus.full), 32'd0);
        chk("async_dout", 32'(bus.data_out), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("async_ovf", 32'(bus.overflow), 32'd0);
        chk("async_unf", 32'(bus.underflow), 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;

        q.delete();
        m_dout = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic w, r, ok_w, ok_r;
            logic [DW-1:0] d;
            // Phases bias toward filling, draining, or mixed traffic to hit wrap and both limits.
            case ((i / 50) % 3)
                0: begin w = ($urandom % 4) != 0; r = ($urandom % 4) == 0; end
                1: begin w = ($urandom % 4) == 0; r = ($urandom % 4) != 0; end
                default: begin w = $urandom % 2; r = $urandom % 2; end
            endcase
            d = DW'($urandom);
            ok_w = w && (q.size() < DEPTH);
            ok_r = r && (q.size() > 0);
            m_ovf |= w && (q.size() == DEPTH);
            m_unf |= r && (q.size() == 0);
            if (ok_r) m_dout = q.pop_front();
            if (ok_w) q.push_back(d);
            cyc(w, r, d);
            chk($sformatf("rnd%0d_dout", i), 32'(bus.data_out), 32'(m_dout));
            chk($sformatf("rnd%0d_empty", i), 32'(bus.empty), 32'(q.size() == 0));
            chk($sformatf("rnd%0d_full", i), 32'(bus.full), 32'(q.size() == DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
            chk($sformatf("rnd%0d_ovf", i), 32'(bus.overflow), 32'(m_ovf));
            chk($sformatf("rnd%0d_unf", i), 32'(bus.underflow), 32'(m_unf));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
